// File: rtl/sc_datamem_io_if.sv
// sc_datamem_io_if: load/store bus plus board I/O for sc_datamem_io.
//   master: CPU/board side - drives addr, datain, we, be, re, in_port;
//           observes dataout, rvalid, out_port, irq.
//   slave : the memory/IO block itself.
//   out_port/in_port pack port k into bits [32k+31:32k].
interface sc_datamem_io_if #(
    parameter int unsigned N_OUT = 3,
    parameter int unsigned N_IN  = 2
);
    logic [31:0]         addr;
    logic [31:0]         datain;
    logic                we;
    logic [3:0]          be;
    logic                re;
    logic [31:0]         dataout;
    logic                rvalid;
    logic [32*N_OUT-1:0] out_port;
    logic [32*N_IN-1:0]  in_port;
    logic                irq;

    modport master (
        output addr, datain, we, be, re, in_port,
        input  dataout, rvalid, out_port, irq
    );

    modport slave (
        input  addr, datain, we, be, re, in_port,
        output dataout, rvalid, out_port, irq
    );
endinterface

// File: rtl/sc_datamem_io.sv
// sc_datamem_io: data memory plus memory-mapped I/O for the single-cycle CPU.
//   clock : rising-edge clock for all state
//   clrn  : asynchronous active-low reset (RAM contents are not reset)
//   bus   : sc_datamem_io_if.slave
//           addr[IO_BIT]=0 -> RAM word addr[log2(DEPTH)+1:2]
//           addr[IO_BIT]=1 -> I/O register r=addr[6:2]:
//             0..7 output regs, 8..15 synchronised inputs,
//             16 change flags (write-1-to-clear), 17 interrupt mask
//           byte-enabled writes, registered reads with one-cycle rvalid,
//           irq = |(flags & mask)
module sc_datamem_io #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned N_OUT       = 3,
    parameter int unsigned N_IN        = 2,
    parameter int unsigned IO_BIT      = 7
) (
    input  logic           clock,
    input  logic           clrn,
    sc_datamem_io_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned OW = 32 * N_OUT;
    localparam int unsigned IW = 32 * N_IN;

    logic [31:0]    mem [DEPTH_WORDS];

    logic [AW-1:0]  word_idx;
    logic           io_sel;
    logic [31:0]    reg_idx;
    logic           wr_ram;
    logic           wr_io;
    logic           unused_addr;

    logic [31:0]    ram_rdata;
    logic [31:0]    io_rdata;

    logic [OW-1:0]  outp_q, outp_d;
    logic [IW-1:0]  s1_q, s2_q, s3_q;
    logic [N_IN-1:0] flag_q, flag_d;
    logic [N_IN-1:0] mask_q, mask_d;
    logic [N_IN-1:0] change;
    logic [N_IN-1:0] flag_clr;
    logic [31:0]    dout_q, dout_d;
    logic           rvalid_q, rvalid_d;

    assign word_idx    = bus.addr[AW+1:2];
    assign io_sel      = bus.addr[IO_BIT];
    assign reg_idx     = {27'd0, bus.addr[6:2]};
    assign wr_ram      = bus.we & ~io_sel;
    assign wr_io       = bus.we & io_sel;
    // Address bits outside the decoded fields are ignored by design.
    assign unused_addr = ^bus.addr;

    // RAM: no reset, byte-lane writes
    always_ff @(posedge clock) begin
        if (wr_ram) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.be[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.datain[8*b +: 8];
                end
            end
        end
    end

    // Sampled before the edge, so a same-cycle write returns the old word.
    assign ram_rdata = mem[word_idx];

    // Per-port change detect on the synchronised side
    always_comb begin
        change = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            change[i] = |(s2_q[32*i +: 32] ^ s3_q[32*i +: 32]);
        end
    end

    // I/O read mux; nonexistent registers read as zero
    always_comb begin
        io_rdata = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (reg_idx == k) begin
                io_rdata = outp_q[32*k +: 32];
            end
        end
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (reg_idx == k + 32'd8) begin
                io_rdata = s2_q[32*k +: 32];
            end
        end
        if (reg_idx == 32'd16) begin
            io_rdata[N_IN-1:0] = flag_q;
        end
        if (reg_idx == 32'd17) begin
            io_rdata[N_IN-1:0] = mask_q;
        end
    end

    // Next-state for I/O registers and read port
    always_comb begin
        outp_d = outp_q;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (wr_io && (reg_idx == k)) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (bus.be[b]) begin
                        outp_d[32*k + 8*b +: 8] = bus.datain[8*b +: 8];
                    end
                end
            end
        end

        // Flag and mask bits all live in byte lane 0 (N_IN <= 8).
        mask_d = mask_q;
        if (wr_io && (reg_idx == 32'd17) && bus.be[0]) begin
            mask_d = bus.datain[N_IN-1:0];
        end

        flag_clr = '0;
        if (wr_io && (reg_idx == 32'd16) && bus.be[0]) begin
            flag_clr = bus.datain[N_IN-1:0];
        end
        // A new change outranks a simultaneous clear of the same bit.
        flag_d = (flag_q & ~flag_clr) | change;

        rvalid_d = bus.re;
        dout_d   = dout_q;
        if (bus.re) begin
            dout_d = io_sel ? io_rdata : ram_rdata;
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            outp_q   <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            flag_q   <= '0;
            mask_q   <= '0;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            outp_q   <= outp_d;
            s1_q     <= bus.in_port;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            flag_q   <= flag_d;
            mask_q   <= mask_d;
            dout_q   <= dout_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.dataout  = dout_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.out_port = outp_q;
    assign bus.irq      = |(flag_q & mask_q);
endmodule

// File: tb/tb_sc_datamem_io.sv
// tb_sc_datamem_io: self-checking bench for sc_datamem_io.
// Directed scenarios plus a randomized run checked against a behavioural
// model (RAM array, output register array, input history queue, flags/mask).
module tb_sc_datamem_io;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NO    = 3;
    localparam int unsigned NI    = 2;
    localparam int unsigned IOB   = 7;
    localparam int unsigned IW    = 32 * NI;
    localparam int unsigned OW    = 32 * NO;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sc_datamem_io_if #(.N_OUT(NO), .N_IN(NI)) bus ();

    sc_datamem_io #(
        .DEPTH_WORDS(DEPTH),
        .N_OUT      (NO),
        .N_IN       (NI),
        .IO_BIT     (IOB)
    ) dut (
        .clock(clk),
        .clrn (rst_n),
        .bus  (bus.slave)
    );

    // Reference model state
    logic [31:0]   m_ram [DEPTH];
    logic [31:0]   m_out [NO];
    logic [NI-1:0] m_flag;
    logic [NI-1:0] m_mask;
    logic [IW-1:0] m_hist [$];   // [0]=two samples back, [1]=sync value, [2]=newest
    logic [31:0]   e_dout;
    logic          e_rvalid;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic logic [31:0] bmerge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = new_v[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int unsigned r;
        logic [31:0] v;
        v = '0;
        if (!a[IOB]) return m_ram[(a >> 2) % DEPTH];
        r = (a >> 2) & 31;
        if (r < NO) v = m_out[r];
        else if (r >= 8 && r < 8 + NI) v = m_hist[1][32*(r-8) +: 32];
        else if (r == 16) v[NI-1:0] = m_flag;
        else if (r == 17) v[NI-1:0] = m_mask;
        return v;
    endfunction

    function automatic logic [OW-1:0] exp_out();
        logic [OW-1:0] v;
        for (int k = 0; k < NO; k++) v[32*k +: 32] = m_out[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NO; k++) m_out[k] = '0;
        m_flag = '0;
        m_mask = '0;
        m_hist.delete();
        repeat (3) m_hist.push_back('0);
        e_dout   = '0;
        e_rvalid = 1'b0;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic w,
                              input logic [3:0] b, input logic r, input logic [IW-1:0] ip);
        int unsigned rn;
        logic [NI-1:0] chg, clr;
        if (r) e_dout = m_read(a);
        e_rvalid = r;
        chg = '0;
        for (int i = 0; i < NI; i++) chg[i] = (m_hist[1][32*i +: 32] != m_hist[0][32*i +: 32]);
        clr = '0;
        if (w) begin
            if (!a[IOB]) m_ram[(a >> 2) % DEPTH] = bmerge(m_ram[(a >> 2) % DEPTH], d, b);
            else begin
                rn = (a >> 2) & 31;
                if (rn < NO) m_out[rn] = bmerge(m_out[rn], d, b);
                else if (rn == 16 && b[0]) clr = d[NI-1:0];
                else if (rn == 17 && b[0]) m_mask = d[NI-1:0];
            end
        end
        m_flag = (m_flag & ~clr) | chg;
        m_hist.push_back(ip);
        void'(m_hist.pop_front());
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic [3:0] b, input logic r);
        bus.addr = a; bus.datain = d; bus.we = w; bus.be = b; bus.re = r;
    endtask

    task automatic tick();
        logic [31:0] a, d;
        logic w, r;
        logic [3:0] b;
        logic [IW-1:0] ip;
        a = bus.addr; d = bus.datain; w = bus.we; b = bus.be; r = bus.re; ip = bus.in_port;
        @(posedge clk);
        model_edge(a, d, w, b, r, ip);
        #1;
    endtask

    task automatic test_reset();
        drive('0, '0, 1'b0, '0, 1'b0);
        bus.in_port = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL reset_dataout: got %h expected 0", bus.dataout); end
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b expected 0", bus.rvalid); end
        n_cmp++; if (bus.out_port !== '0) begin n_bad++; $display("FAIL reset_out_port: got %h expected 0", bus.out_port); end
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
        tick();
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL reset_first_edge_irq: got %b expected 0", bus.irq); end
    endtask

    task automatic test_ram_bytes();
        drive(32'h0C, 32'h11223344, 1'b1, 4'hF, 1'b0);    tick();
        drive(32'h0C, 32'h0000AA00, 1'b1, 4'b0010, 1'b0); tick();
        drive(32'h0C, 32'h0, 1'b0, 4'h0, 1'b1);           tick();
        n_cmp++; if (bus.dataout !== 32'h1122AA44) begin n_bad++; $display("FAIL ram_byte_read: got %h expected 1122aa44", bus.dataout); end
        n_cmp++; if (bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL ram_rvalid_high: got %b expected 1", bus.rvalid); end
        drive(32'h0C, 32'h0, 1'b0, 4'h0, 1'b0); tick();
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL ram_rvalid_drop: got %b expected 0", bus.rvalid); end
        n_cmp++; if (bus.dataout !== 32'h1122AA44) begin n_bad++; $display("FAIL ram_dout_hold: got %h expected 1122aa44", bus.dataout); end
        drive(32'h0C + 4 * DEPTH, 32'h0, 1'b0, 4'h0, 1'b1); tick();
        n_cmp++; if (bus.dataout !== 32'h1122AA44) begin n_bad++; $display("FAIL ram_wrap_read: got %h expected 1122aa44", bus.dataout); end
        drive(32'h0C, 32'hFFFF_FFFF, 1'b1, 4'h0, 1'b1); tick();
        drive(32'h0F, 32'h0, 1'b0, 4'h0, 1'b1); tick();
        n_cmp++; if (bus.dataout !== 32'h1122AA44) begin n_bad++; $display("FAIL ram_be0_noop: got %h expected 1122aa44", bus.dataout); end
        drive('0, '0, 1'b0, '0, 1'b0); tick();
    endtask

    task automatic test_rw_same();
        drive(32'h10, 32'd5, 1'b1, 4'hF, 1'b0); tick();
        drive(32'h10, 32'd9, 1'b1, 4'hF, 1'b1); tick();
        n_cmp++; if (bus.dataout !== 32'd5) begin n_bad++; $display("FAIL rbw_old_data: got %h expected 5", bus.dataout); end
        drive(32'h10, 32'd0, 1'b0, 4'h0, 1'b1); tick();
        n_cmp++; if (bus.dataout !== 32'd9) begin n_bad++; $display("FAIL rbw_new_data: got %h expected 9", bus.dataout); end
        n_cmp++; if (bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid: got %b expected 1", bus.rvalid); end
        drive('0, '0, 1'b0, '0, 1'b0); tick();
    endtask

    task automatic test_out_ports();
        logic [OW-1:0] op;
        drive(32'h84, 32'hDEADBEEF, 1'b1, 4'hF, 1'b0); tick();
        op = bus.out_port;
        n_cmp++; if (op[63:32] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL out_port1: got %h expected deadbeef", op[63:32]); end
        drive(32'h9C, 32'h12345678, 1'b1, 4'hF, 1'b0); tick();
        n_cmp++; if (bus.out_port !== {32'h0, 32'hDEADBEEF, 32'h0}) begin n_bad++; $display("FAIL out_r7_ignored: got %h expected %h", bus.out_port, {32'h0, 32'hDEADBEEF, 32'h0}); end
        drive(32'h9C, 32'h0, 1'b0, 4'h0, 1'b1); tick();
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL out_r7_read: got %h expected 0", bus.dataout); end
        drive(32'h84, 32'h0, 1'b0, 4'h0, 1'b1); tick();
        n_cmp++; if (bus.dataout !== 32'hDEADBEEF) begin n_bad++; $display("FAIL out_r1_read: got %h expected deadbeef", bus.dataout); end
        drive(32'h88, 32'hCAFEF00D, 1'b1, 4'b1100, 1'b0); tick();
        op = bus.out_port;
        n_cmp++; if (op[95:64] !== 32'hCAFE0000) begin n_bad++; $display("FAIL out_r2_bytes: got %h expected cafe0000", op[95:64]); end
        drive('0, '0, 1'b0, '0, 1'b0); tick();
    endtask

    task automatic test_input_flag();
        drive(32'hC4, 32'h1, 1'b1, 4'hF, 1'b0); tick();
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL mask_only_irq: got %b expected 0", bus.irq); end
        bus.in_port = {32'h0, 32'h5};
        drive(32'hA0, 32'h0, 1'b0, 4'h0, 1'b1);
        tick();
        tick();
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL sync_edge2_read: got %h expected 0", bus.dataout); end
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL sync_edge2_irq: got %b expected 0", bus.irq); end
        tick();
        n_cmp++; if (bus.dataout !== 32'h5) begin n_bad++; $display("FAIL sync_edge3_read: got %h expected 5", bus.dataout); end
        n_cmp++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL flag_irq_set: got %b expected 1", bus.irq); end
        drive(32'hC0, 32'h0, 1'b0, 4'h0, 1'b1); tick();
        n_cmp++; if (bus.dataout !== 32'h1) begin n_bad++; $display("FAIL flag_read: got %h expected 1", bus.dataout); end
        drive(32'hC0, 32'h1, 1'b1, 4'hF, 1'b0); tick();
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL w1c_irq_clear: got %b expected 0", bus.irq); end
        drive('0, '0, 1'b0, '0, 1'b0); tick();
    endtask

    task automatic test_set_beats_clear();
        bus.in_port = {32'h0, 32'h7};
        repeat (3) tick();
        n_cmp++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL sbc_pre_irq: got %b expected 1", bus.irq); end
        bus.in_port = {32'h0, 32'h9};
        tick();
        tick();
        drive(32'hC0, 32'h1, 1'b1, 4'hF, 1'b0); tick();
        n_cmp++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL set_beats_clear_irq: got %b expected 1", bus.irq); end
        drive(32'hC0, 32'h0, 1'b0, 4'h0, 1'b1); tick();
        n_cmp++; if (bus.dataout !== 32'h1) begin n_bad++; $display("FAIL set_beats_clear_flag: got %h expected 1", bus.dataout); end
        drive(32'hC0, 32'h1, 1'b1, 4'hF, 1'b0); tick();
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL plain_clear_irq: got %b expected 0", bus.irq); end
        drive('0, '0, 1'b0, '0, 1'b0);
        bus.in_port = {32'h0, 32'h10};
        repeat (3) tick();
        n_cmp++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL reflag_irq: got %b expected 1", bus.irq); end
    endtask

    task automatic test_async_reset();
        drive(32'h0C, 32'h0, 1'b0, 4'h0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_port !== '0) begin n_bad++; $display("FAIL areset_out_port: got %h expected 0", bus.out_port); end
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL areset_dataout: got %h expected 0", bus.dataout); end
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL areset_rvalid: got %b expected 0", bus.rvalid); end
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL areset_irq: got %b expected 0", bus.irq); end
        @(posedge clk);
        #2;
        bus.re = 1'b0;
        rst_n = 1'b1;
        model_reset();
        tick();
        n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL areset_no_rvalid: got %b expected 0", bus.rvalid); end
        drive(32'h0C, 32'h0, 1'b0, 4'h0, 1'b1); tick();
        n_cmp++; if (bus.dataout !== 32'h1122AA44) begin n_bad++; $display("FAIL areset_ram_kept: got %h expected 1122aa44", bus.dataout); end
        drive('0, '0, 1'b0, '0, 1'b0); tick();
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [IW-1:0] ip;
        int unsigned r;
        for (int w = 0; w < DEPTH; w++) begin
            drive(32'(w) << 2, $urandom, 1'b1, 4'hF, 1'b0);
            tick();
        end
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = {24'h0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
            end else begin
                r = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 17) : $urandom_range(0, 31);
                a = {24'h0, 1'b1, 5'(r), 2'($urandom_range(0, 3))};
            end
            drive(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            ip = bus.in_port;
            for (int i = 0; i < NI; i++) if ($urandom_range(0, 7) == 0) ip[32*i +: 32] = $urandom;
            bus.in_port = ip;
            tick();
            n_cmp++; if (bus.dataout !== e_dout) begin n_bad++; $display("FAIL rnd_dataout cyc %0d: got %h expected %h", n, bus.dataout, e_dout); end
            n_cmp++; if (bus.rvalid !== e_rvalid) begin n_bad++; $display("FAIL rnd_rvalid cyc %0d: got %b expected %b", n, bus.rvalid, e_rvalid); end
            n_cmp++; if (bus.out_port !== exp_out()) begin n_bad++; $display("FAIL rnd_out_port cyc %0d: got %h expected %h", n, bus.out_port, exp_out()); end
            n_cmp++; if (bus.irq !== |(m_flag & m_mask)) begin n_bad++; $display("FAIL rnd_irq cyc %0d: got %b expected %b", n, bus.irq, |(m_flag & m_mask)); end
        end
        drive('0, '0, 1'b0, '0, 1'b0); tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ram_bytes();
        test_rw_same();
        test_out_ports();
        test_input_flag();
        test_set_beats_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sc_datamem_io.md
# sc_datamem_io

Parametrised single-clock data memory with a memory-mapped I/O block for the single-cycle CPU. It replaces the fixed 32-word RAM and two-input/three-output port arrangement with the following: configurable RAM depth, configurable port counts, byte-enable writes, registered reads with a valid strobe, synchronised input ports, and per-input change-detect flags that drive a maskable interrupt. It sits between the CPU datapath (load/store address, store data, load result) and the board I/O.

## Interface
Parameters:
- `DEPTH_WORDS`, 32: RAM depth in 32-bit words; power of two, 16–1024.
- `N_OUT`, 3: number of output port registers, 1–8.
- `N_IN`, 2: number of input ports, 1–8.
- `IO_BIT`, 7: address bit selecting I/O space (1) versus RAM (0); must exceed log2(DEPTH_WORDS)+1.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `clrn` in 1: asynchronous active-low reset.
- `addr` in 32: byte address; bits [1:0] ignored.
- `datain` in 32: store data.
- `we` in 1: write request, sampled at the rising edge.
- `be` in 4: byte enables for the write; be[0] covers datain[7:0].
- `re` in 1: read request, sampled at the rising edge.
- `dataout` out 32: read data, registered.
- `rvalid` out 1: high for exactly one cycle when `dataout` holds new read data.
- `out_port` out 32*N_OUT: output port registers; port k is bits [32k+31:32k].
- `in_port` in 32*N_IN: asynchronous board inputs, same packing as `out_port`.
- `irq` out 1: OR of (change flags AND mask).

## Operation
- RAM space (addr[IO_BIT]=0):
  - Word index is addr[log2(DEPTH_WORDS)+1:2]; higher bits below IO_BIT are ignored, so addresses wrap modulo the depth.
  - RAM contents are not reset.
- I/O space (addr[IO_BIT]=1): register index r = addr[6:2].
  - r=0..7: output register r, read/write. Exists only if r<N_OUT.
  - r=8..15: input port r-8, read-only, returns the synchronised value. Exists only if r-8<N_IN.
  - r=16: change-flag register, bits [N_IN-1:0]. Read returns the flags. Write 1 clears the bit, write 0 leaves it unchanged.
  - r=17: interrupt mask, bits [N_IN-1:0], read/write.
  - Unmapped or nonexistent r: reads return 0, writes are ignored. Unused upper bits of r=16/17 read 0.
- Byte enables apply to every writable target: RAM, output registers, mask, and W1C flags. A byte with be=0 is left unchanged. be=0000 with we=1 is a no-op.
- Each input port passes through a two-flop synchroniser (s1→s2). s2 is the "synchronised value". A third register s3 holds the previous s2.
- Change flag i sets on any edge where s2[i] != s3[i] (any bit of port i differs).
- If a flag set and a W1C clear of the same bit occur in the same cycle, set wins.
- irq = |(flags & mask), derived combinationally from registers only.

## Timing
- Write: takes effect at the rising edge where we=1. The new out_port value is visible immediately after that edge.
- Read: the edge where re=1 captures data. dataout and rvalid=1 are valid after that edge; rvalid drops the following cycle unless re is high again.
- dataout holds its last value when there is no read.
- Back-to-back reads: one result per cycle.
- Simultaneous we and re to the same address: read returns the old data (read-before-write). A following read returns the new data.
- Input latency: an in_port change is readable 2 edges later. Its flag sets on the 3rd edge. irq follows in the same cycle the flag sets.
- Reset (clrn=0, asynchronous) clears: out_port, flags, mask, s1/s2/s3, dataout, and rvalid to 0. irq therefore goes to 0.
- In-flight read during reset is discarded: rvalid=0 after reset is released.
- The first edge after reset release produces no spurious flags, because s2 and s3 are both 0.

## Test plan
- RAM byte write: write 0x11223344 to address 0x0C, then write 0xAA with be=0010. Read 0x0C → dataout=0x1122AA44, rvalid=1 for 1 cycle. Read 0x0C+4*DEPTH_WORDS (below IO_BIT) → same value (wrap).
- Same-cycle read/write: word 0x10 holds 5; issue we=1, re=1 with data 9 → dataout=5. Read again → 9.
- Output ports: write 0xDEADBEEF to I/O r=1 → out_port[63:32]=0xDEADBEEF after the edge. Write to r=7 with N_OUT=3 → no out_port change. Read r=7 → 0.
- Input sync and change flag: set mask=0x1. Drive in_port0 from 0 to 0x5 → r=8 reads 0x5 from the 2nd edge, flag0 sets and irq=1 on the 3rd edge. Write 0x1 to r=16 → irq=0.
- Set-beats-clear: time the W1C of flag0 to coincide with a new in_port0 change reaching s2 → flag0 stays 1.
- Async reset mid-operation: assert clrn=0 between edges with re=1 pending and out_port≠0 → all outputs 0 immediately, no rvalid after release, RAM contents retained.
